// File: rtl/fft_frame_sched.sv
// Shares one in-place 64-point FFT core between two requesters: round-robin grant,
// stream the granted frame in, then forward the 32 two-sample output beats tagged by requester.
module fft_frame_sched #(
  parameter int unsigned W       = 16,
  parameter int unsigned N       = 64,
  parameter int unsigned TIMEOUT = 511,
  localparam int unsigned IdxW   = $clog2(N),
  localparam int unsigned BeatW  = IdxW - 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [1:0]           req,
  output logic [1:0]           gnt,
  output logic [IdxW-1:0]      sample_idx,
  input  logic signed [W-1:0]  s0_re,
  input  logic signed [W-1:0]  s0_im,
  input  logic signed [W-1:0]  s1_re,
  input  logic signed [W-1:0]  s1_im,
  output logic                 core_start,
  output logic                 core_valid,
  output logic signed [W-1:0]  core_re,
  output logic signed [W-1:0]  core_im,
  input  logic                 core_out_start,
  input  logic signed [W-1:0]  core_re0,
  input  logic signed [W-1:0]  core_im0,
  input  logic signed [W-1:0]  core_re1,
  input  logic signed [W-1:0]  core_im1,
  output logic                 res_valid,
  output logic                 res_tag,
  output logic [BeatW-1:0]     res_idx,
  output logic                 res_last,
  output logic signed [W-1:0]  res_re0,
  output logic signed [W-1:0]  res_im0,
  output logic signed [W-1:0]  res_re1,
  output logic signed [W-1:0]  res_im1,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int unsigned WdW = 10;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDrain} state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             tag_q, tag_d;
  logic             prio_q, prio_d;  // requester favoured on a tie
  logic [WdW-1:0]   wd_q, wd_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             capture;
  logic [BeatW-1:0] cap_idx;
  logic             win;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    prio_d      = prio_q;
    wd_d        = wd_q;
    beat_d      = beat_q;
    capture     = 1'b0;
    err_timeout = 1'b0;
    win         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          win     = (req == 2'b11) ? prio_q : req[1];
          tag_d   = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxW'(N - 1)) begin
          gnt_d   = 2'b00;
          prio_d  = ~tag_q;
          wd_d    = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (core_out_start) begin
          capture = 1'b1;
          beat_d  = BeatW'(1);
          state_d = StDrain;
        end else if (wd_q == WdW'(TIMEOUT)) begin
          err_timeout = 1'b1;
          state_d     = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDrain: begin
        capture = 1'b1;
        beat_d  = beat_q + 1'b1;
        if (beat_q == '1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Beat 0 is captured from WAIT, later beats from DRAIN.
  assign cap_idx = (state_q == StDrain) ? beat_q : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      tag_q   <= 1'b0;
      prio_q  <= 1'b0;
      wd_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      prio_q  <= prio_d;
      wd_q    <= wd_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      res_valid <= 1'b0;
      res_tag   <= 1'b0;
      res_idx   <= '0;
      res_last  <= 1'b0;
      res_re0   <= '0;
      res_im0   <= '0;
      res_re1   <= '0;
      res_im1   <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_tag   <= tag_q;
      res_idx   <= cap_idx;
      res_last  <= (cap_idx == '1);
      res_re0   <= core_re0;
      res_im0   <= core_im0;
      res_re1   <= core_re1;
      res_im1   <= core_im1;
    end else begin
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end
  end

  assign gnt        = gnt_q;
  assign sample_idx = idx_q;
  assign busy       = (state_q != StIdle);
  assign core_valid = (state_q == StLoad);
  assign core_start = core_valid && (idx_q == '0);
  assign core_re    = core_valid ? (tag_q ? s1_re : s0_re) : '0;
  assign core_im    = core_valid ? (tag_q ? s1_im : s0_im) : '0;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Scoreboard bench for fft_frame_sched: stimulus plays both requesters and the FFT core,
// pushing expected result beats; a monitor pops and compares on every res_valid.
module tb_fft_frame_sched;

  localparam int W       = 16;
  localparam int TIMEOUT = 511;

  logic          clk, nrst;
  logic [1:0]    req, gnt;
  logic [5:0]    sample_idx;
  logic [W-1:0]  s0_re, s0_im, s1_re, s1_im;
  logic          core_start, core_valid, core_out_start;
  logic [W-1:0]  core_re, core_im, core_re0, core_im0, core_re1, core_im1;
  logic          res_valid, res_tag, res_last, busy, err_timeout;
  logic [4:0]    res_idx;
  logic [W-1:0]  res_re0, res_im0, res_re1, res_im1;

  typedef struct packed {
    logic        tag;
    logic [4:0]  idx;
    logic        last;
    logic [63:0] dat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total, bad, fr_no;

  fft_frame_sched dut (
    .clk(clk), .nrst(nrst), .req(req), .gnt(gnt), .sample_idx(sample_idx),
    .s0_re(s0_re), .s0_im(s0_im), .s1_re(s1_re), .s1_im(s1_im),
    .core_start(core_start), .core_valid(core_valid), .core_re(core_re), .core_im(core_im),
    .core_out_start(core_out_start), .core_re0(core_re0), .core_im0(core_im0),
    .core_re1(core_re1), .core_im1(core_im1),
    .res_valid(res_valid), .res_tag(res_tag), .res_idx(res_idx), .res_last(res_last),
    .res_re0(res_re0), .res_im0(res_im0), .res_re1(res_re1), .res_im1(res_im1),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] smp_re(input logic t, input logic [5:0] k);
    return t ? 16'(int'(k) * 3 + 1000) : 16'(k);
  endfunction

  function automatic logic [15:0] smp_im(input logic t, input logic [5:0] k);
    return t ? 16'(-(int'(k) * 7) - 5) : 16'(-int'(k));
  endfunction

  function automatic logic [63:0] beat_dat(input int fr, input int b);
    logic [15:0] r0, i0, r1, i1;
    r0 = 16'(fr * 1000 + b);
    i0 = 16'(-(fr * 1000 + b));
    r1 = (b == 31) ? 16'h7fff : 16'(b * 2);
    i1 = (b == 0) ? 16'h8000 : 16'(~b);
    return {r0, i0, r1, i1};
  endfunction

  assign s0_re = smp_re(1'b0, sample_idx);
  assign s0_im = smp_im(1'b0, sample_idx);
  assign s1_re = smp_re(1'b1, sample_idx);
  assign s1_im = smp_im(1'b1, sample_idx);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst && res_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res_unexpected: got beat idx %0d tag %0d want no beat", res_idx, res_tag);
      end else begin
        mon_e = sb_q.pop_front();
        chk("res_beat", {res_tag, res_idx, res_last, res_re0, res_im0, res_re1, res_im1}, mon_e);
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_ctl", {gnt, sample_idx, core_start, core_valid, core_re, core_im, busy, err_timeout},
        '0);
    chk("rst_res", {res_valid, res_tag, res_idx, res_last, res_re0, res_im0, res_re1, res_im1},
        '0);
  endtask

  // delay: cycles from core_start to core_out_start, negative means the core never answers.
  task automatic run_frame(input logic tag, input int gwait, input int drop, input int delay,
                           input bit spur_l, input bit spur_d, input int rst_beat);
    bit         got;
    exp_t       e;
    logic [1:0] g;
    got = 0;
    g   = tag ? 2'b10 : 2'b01;
    for (int i = 0; i < gwait; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        got = 1;
        break;
      end
    end
    chk("grant", gnt, g);
    if (!got) return;
    fr_no++;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      chk("load", {gnt, sample_idx, core_start, core_valid, busy, core_re, core_im},
          {g, 6'(k), k == 0, 1'b1, 1'b1, smp_re(tag, 6'(k)), smp_im(tag, 6'(k))});
      if (k == drop) req = 2'b00;
      core_out_start = spur_l && (k == 10);
    end
    @(negedge clk);
    chk("wait_entry", {gnt, core_valid, busy, err_timeout}, {2'b00, 1'b0, 1'b1, 1'b0});
    if (delay < 0) begin
      for (int n = 1; n <= TIMEOUT; n++) begin
        @(negedge clk);
        chk("watchdog", {err_timeout, busy}, {n == TIMEOUT, 1'b1});
      end
      @(negedge clk);
      chk("after_abort", {err_timeout, busy, gnt}, '0);
      return;
    end
    repeat (delay - 64) @(negedge clk);
    for (int b = 0; b < 32; b++) begin
      if (b > 0) @(negedge clk);
      if (b == rst_beat) begin
        #2 nrst = 1'b0;
        #1 check_reset_outputs();
        core_out_start = 1'b0;
        {core_re0, core_im0, core_re1, core_im1} = '0;
        return;
      end
      core_out_start = (b == 0) || (spur_d && b == 5);
      {core_re0, core_im0, core_re1, core_im1} = beat_dat(fr_no, b);
      e.tag  = tag;
      e.idx  = 5'(b);
      e.last = (b == 31);
      e.dat  = beat_dat(fr_no, b);
      sb_q.push_back(e);
    end
    @(negedge clk);
    core_out_start = 1'b0;
    {core_re0, core_im0, core_re1, core_im1} = '0;
    chk("frame_end", {busy, err_timeout}, 2'b00);
  endtask

  initial begin
    clk = 1'b0;
    nrst = 1'b0;
    req = 2'b00;
    core_out_start = 1'b0;
    {core_re0, core_im0, core_re1, core_im1} = '0;
    total = 0;
    bad = 0;
    fr_no = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    nrst = 1'b1;
    @(negedge clk);

    // Tie: req held on both, back-to-back grants 0, 1, 0
    req = 2'b11;
    run_frame(1'b0, 5, -1, 64, 0, 0, -1);
    run_frame(1'b1, 1, -1, 70, 0, 0, -1);
    run_frame(1'b0, 1, 0, 100, 0, 0, -1);

    // Single frame, core answers 130 cycles after start
    req = 2'b01;
    run_frame(1'b0, 5, 0, 130, 0, 0, -1);

    // Spurious core_out_start in LOAD idx 10 and DRAIN beat 5
    req = 2'b10;
    run_frame(1'b1, 5, 0, 80, 1, 1, -1);

    // req drops mid-LOAD
    req = 2'b01;
    run_frame(1'b0, 5, 20, 90, 0, 0, -1);

    // Core never answers
    req = 2'b10;
    run_frame(1'b1, 5, 0, -1, 0, 0, -1);

    // Reset at DRAIN beat 12, then requester 1 alone
    req = 2'b01;
    run_frame(1'b0, 5, 0, 70, 0, 0, 12);
    req = 2'b10;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    nrst = 1'b1;
    run_frame(1'b1, 5, 0, 64, 0, 0, -1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
